// File: rtl/sprite_pkg.sv
// Shared sprite geometry, ROM address layout and pixel format for the renderer and sprite ROM.
// Latency: none (constants, types and a pure function only).
// Backpressure: not applicable.
package sprite_pkg;

    // Sprite geometry and ROM contents description
    localparam int WIDTH    = 16;
    localparam int HEIGHT   = 16;
    localparam int NSPRITES = 4;

    // Pixel format: 4-bit palette index, one code reserved as see-through
    localparam int          PIX_W       = 4;
    localparam logic [3:0]  TRANSPARENT = 4'h0;

    // Raster coordinate width coming from the VGA timing generator
    localparam int POS_W = 10;

    // ROM address fields: {frame, row, col}
    localparam int COL_W  = $clog2(WIDTH);
    localparam int ROW_W  = $clog2(HEIGHT);
    localparam int FRM_W  = (NSPRITES > 1) ? $clog2(NSPRITES) : 1;
    localparam int ADDR_W = FRM_W + ROW_W + COL_W;

    // Animation step counter width; covers ANIM_DIV up to 255
    localparam int FCNT_W = 8;

    typedef struct packed {
        logic [FRM_W-1:0] frame;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } rom_addr_t;

    // Sprite placement captured once per video frame
    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
        logic             flip;
    } shadow_t;

    // Assemble a ROM address from its fields
    function automatic rom_addr_t pack_addr(input logic [FRM_W-1:0] frame,
                                            input logic [ROW_W-1:0] row,
                                            input logic [COL_W-1:0] col);
        rom_addr_t a;
        a.frame = frame;
        a.row   = row;
        a.col   = col;
        return a;
    endfunction

endpackage

// File: rtl/sprite_anim.sv
// Animation sequencer: counts video frames and steps the sprite frame index every ANIM_DIV frames.
// Latency: new index visible the cycle after the frame_start pulse that advances it.
// Backpressure: none; frame_start is a free-running pulse, anim_en low freezes all state.
module sprite_anim
    import sprite_pkg::*;
#(
    parameter int NSPRITES = sprite_pkg::NSPRITES,
    parameter int ANIM_DIV = 8,
    parameter int FRM_W    = sprite_pkg::FRM_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             frame_start_i,
    input  logic             anim_en_i,
    output logic [FRM_W-1:0] frame_o
);

    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [FRM_W-1:0]  frame_q, frame_d;

    // Step only on frame_start so a frame in progress never changes animation frame
    always_comb begin
        fcnt_d  = fcnt_q;
        frame_d = frame_q;
        if (frame_start_i && anim_en_i) begin
            if (fcnt_q == FCNT_W'(ANIM_DIV - 1)) begin
                fcnt_d  = '0;
                frame_d = (frame_q == FRM_W'(NSPRITES - 1)) ? '0 : frame_q + 1'b1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Counter and frame index registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fcnt_q  <= '0;
            frame_q <= '0;
        end else begin
            fcnt_q  <= fcnt_d;
            frame_q <= frame_d;
        end
    end

    assign frame_o = frame_q;

endmodule

// File: rtl/sprite_render.sv
// Sprite overlay: hit-tests the raster against a latched sprite box and looks up its pixel in ROM.
// Latency: exactly 3 cycles from raster position to pix_on/pix_color, one pixel per cycle.
// Backpressure: none; fully pipelined, never stalls, ROM must answer one cycle after rom_add.
module sprite_render
    import sprite_pkg::*;
#(
    parameter int              WIDTH       = sprite_pkg::WIDTH,
    parameter int              HEIGHT      = sprite_pkg::HEIGHT,
    parameter int              NSPRITES    = sprite_pkg::NSPRITES,
    parameter int              ANIM_DIV    = 8,
    parameter logic [PIX_W-1:0] TRANSPARENT = sprite_pkg::TRANSPARENT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [POS_W-1:0]  px,
    input  logic [POS_W-1:0]  py,
    input  logic              px_valid,
    input  logic              frame_start,
    input  logic [POS_W-1:0]  spr_x,
    input  logic [POS_W-1:0]  spr_y,
    input  logic              spr_flip,
    input  logic              anim_en,
    output logic [ADDR_W-1:0] rom_add,
    input  logic [PIX_W-1:0]  rom_pixel,
    output logic              pix_on,
    output logic [PIX_W-1:0]  pix_color
);

    // ------------------------------------------------------------------
    // Shadow placement: captured at the start of vertical blanking so the
    // sprite never tears mid-frame. armed stays low after reset until the
    // first capture, which keeps a half-drawn frame blank.
    // ------------------------------------------------------------------
    shadow_t shadow_q, shadow_d;
    logic    armed_q,  armed_d;

    // Capture requested placement on frame_start; hit test this cycle still sees the old copy
    always_comb begin
        shadow_d = shadow_q;
        armed_d  = armed_q;
        if (frame_start) begin
            shadow_d.x    = spr_x;
            shadow_d.y    = spr_y;
            shadow_d.flip = spr_flip;
            armed_d       = 1'b1;
        end
    end

    // Shadow and armed registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            armed_q  <= armed_d;
        end
    end

    // ------------------------------------------------------------------
    // Animation frame index
    // ------------------------------------------------------------------
    logic [FRM_W-1:0] frame_idx;

    sprite_anim #(
        .NSPRITES (NSPRITES),
        .ANIM_DIV (ANIM_DIV),
        .FRM_W    (FRM_W)
    ) u_anim (
        .clk           (clk),
        .rstn          (rstn),
        .frame_start_i (frame_start),
        .anim_en_i     (anim_en),
        .frame_o       (frame_idx)
    );

    // ------------------------------------------------------------------
    // Stage 0: hit test and address formation. Box edges are computed one
    // bit wider than the raster so a sprite placed near column 1023 ends
    // at 1024+ instead of wrapping back to column 0.
    // ------------------------------------------------------------------
    logic [POS_W:0]   px_ext, py_ext, sx_ext, sy_ext;
    logic [POS_W:0]   x_end, y_end;
    logic             in_x, in_y, hit;
    logic [COL_W-1:0] dx, col;
    logic [ROW_W-1:0] dy;

    assign px_ext = {1'b0, px};
    assign py_ext = {1'b0, py};
    assign sx_ext = {1'b0, shadow_q.x};
    assign sy_ext = {1'b0, shadow_q.y};
    assign x_end  = sx_ext + (POS_W+1)'(WIDTH);
    assign y_end  = sy_ext + (POS_W+1)'(HEIGHT);

    // Inclusive top-left, exclusive bottom-right box test against shadow placement
    always_comb begin
        in_x = (px_ext >= sx_ext) && (px_ext < x_end);
        in_y = (py_ext >= sy_ext) && (py_ext < y_end);
        hit  = px_valid && armed_q && in_x && in_y;
    end

    // Offsets inside the box; only the low bits matter once the hit is known.
    // Mirroring reads the sprite row right-to-left for a left-facing sprite.
    always_comb begin
        dx  = px[COL_W-1:0] - shadow_q.x[COL_W-1:0];
        dy  = py[ROW_W-1:0] - shadow_q.y[ROW_W-1:0];
        col = shadow_q.flip ? (COL_W'(WIDTH - 1) - dx) : dx;
    end

    // ------------------------------------------------------------------
    // Stage 1: ROM address and hit flag. The address holds on misses so
    // the ROM does not toggle outside the sprite.
    // ------------------------------------------------------------------
    rom_addr_t addr_q, addr_d;
    logic      hit_d1_q, hit_d1_d;

    // Next address and first pipeline hit flag
    always_comb begin
        addr_d   = addr_q;
        hit_d1_d = hit;
        if (hit) begin
            addr_d = pack_addr(frame_idx, dy, col);
        end
    end

    // Stage 1 registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q   <= '0;
            hit_d1_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            hit_d1_q <= hit_d1_d;
        end
    end

    assign rom_add = addr_q;

    // ------------------------------------------------------------------
    // Stage 2: hit flag waits alongside the ROM read.
    // ------------------------------------------------------------------
    logic hit_d2_q, hit_d2_d;

    // Delay hit to line up with rom_pixel
    always_comb begin
        hit_d2_d = hit_d1_q;
    end

    // Stage 2 register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hit_d2_q <= 1'b0;
        end else begin
            hit_d2_q <= hit_d2_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: output pixel. Transparent codes and misses give a clean
    // zero colour so the downstream mux can key purely on pix_on.
    // ------------------------------------------------------------------
    logic             pix_on_q, pix_on_d;
    logic [PIX_W-1:0] pix_color_q, pix_color_d;

    // Opaque test and colour gating
    always_comb begin
        pix_on_d    = hit_d2_q && (rom_pixel != TRANSPARENT);
        pix_color_d = pix_on_d ? rom_pixel : '0;
    end

    // Output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_on_q    <= 1'b0;
            pix_color_q <= '0;
        end else begin
            pix_on_q    <= pix_on_d;
            pix_color_q <= pix_color_d;
        end
    end

    assign pix_on    = pix_on_q;
    assign pix_color = pix_color_q;

endmodule

// File: tb/tb_sprite_render.sv
// Bench for sprite_render: behavioural ROM, reference placement/animation model and output scoreboard.
// Latency: expected pixel pushed when a raster position is driven, popped three clocks later.
// Backpressure: none; one raster position per clock.
module tb_sprite_render;

    localparam int         W      = 16;
    localparam int         H      = 16;
    localparam int         NSPR   = 4;
    localparam int         DIV    = 8;
    localparam logic [3:0] TRANSP = 4'h0;

    logic       clk = 1'b0;
    logic       rstn;
    logic [9:0] px, py, spr_x, spr_y;
    logic       px_valid, frame_start, spr_flip, anim_en;
    logic [9:0] rom_add;
    logic [3:0] rom_pixel;
    logic       pix_on;
    logic [3:0] pix_color;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard of expected {pix_on, pix_color}
    logic [4:0] exp_q[$];

    // Reference model state
    int         m_sx, m_sy, m_frame, m_fcnt;
    logic       m_flip, m_armed;
    logic [9:0] m_add;

    always #5 clk = ~clk;

    // Sprite ROM contents: address 0 holds 5, address 11 is transparent
    function automatic logic [3:0] rom_word(input logic [9:0] a);
        int v;
        if (a == 10'd0) return 4'h5;
        v = (int'(a) * 7 + 3) & 15;
        return 4'(v);
    endfunction

    // Synchronous ROM: data one clock after address
    always @(posedge clk) rom_pixel <= rom_word(rom_add);

    sprite_render dut (
        .clk         (clk),
        .rstn        (rstn),
        .px          (px),
        .py          (py),
        .px_valid    (px_valid),
        .frame_start (frame_start),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .spr_flip    (spr_flip),
        .anim_en     (anim_en),
        .rom_add     (rom_add),
        .rom_pixel   (rom_pixel),
        .pix_on      (pix_on),
        .pix_color   (pix_color)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Asynchronous reset, asserted away from any clock edge
    task automatic do_reset();
        rstn        = 1'b0;
        px_valid    = 1'b0;
        frame_start = 1'b0;
        #2;
        check("rst_rom_add", 16'(rom_add), 16'h0);
        check("rst_pixel", 16'({pix_on, pix_color}), 16'h0);
        m_sx = 0; m_sy = 0; m_flip = 1'b0; m_armed = 1'b0;
        m_frame = 0; m_fcnt = 0; m_add = 10'h0;
        exp_q.delete();
        exp_q.push_back(5'h0);
        exp_q.push_back(5'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
    endtask

    // One raster clock: drive, predict, advance model, compare
    task automatic step(input int x, input int y, input logic v, input logic fs);
        int         dx, dy, col;
        logic       hit;
        logic [9:0] addr, add_next;
        logic [3:0] w;
        logic [4:0] e;
        px          = 10'(x);
        py          = 10'(y);
        px_valid    = v;
        frame_start = fs;
        hit = v && m_armed && (x >= m_sx) && (x < m_sx + W) && (y >= m_sy) && (y < m_sy + H);
        add_next = m_add;
        if (hit) begin
            dx       = x - m_sx;
            dy       = y - m_sy;
            col      = m_flip ? (W - 1 - dx) : dx;
            addr     = 10'(m_frame * 256 + dy * 16 + col);
            add_next = addr;
            w        = rom_word(addr);
            exp_q.push_back((w != TRANSP) ? {1'b1, w} : 5'h0);
        end else begin
            exp_q.push_back(5'h0);
        end
        @(posedge clk);
        m_add = add_next;
        if (fs) begin
            m_sx    = int'(spr_x);
            m_sy    = int'(spr_y);
            m_flip  = spr_flip;
            m_armed = 1'b1;
            if (anim_en) begin
                if (m_fcnt == DIV - 1) begin
                    m_fcnt  = 0;
                    m_frame = (m_frame + 1) % NSPR;
                end else begin
                    m_fcnt++;
                end
            end
        end
        #1;
        check("rom_add", 16'(rom_add), 16'(m_add));
        if (exp_q.size() >= 3) begin
            e = exp_q.pop_front();
            check("pixel", 16'({pix_on, pix_color}), 16'(e));
        end
        frame_start = 1'b0;
    endtask

    task automatic scan_row(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) step(x, y, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        px = '0; py = '0; px_valid = 1'b0; frame_start = 1'b0;
        spr_x = 10'd100; spr_y = 10'd50; spr_flip = 1'b0; anim_en = 1'b0;
        do_reset();

        // Not armed yet: sprite area must stay blank
        scan_row(50, 98, 104);
        idle(3);
        check("unarmed_pixel", 16'({pix_on, pix_color}), 16'h0);

        // Basic hit at top-left
        step(0, 0, 1'b0, 1'b1);
        step(100, 50, 1'b1, 1'b0);
        check("tl_rom_add", 16'(rom_add), 16'h000);
        step(101, 50, 1'b1, 1'b0);
        step(102, 50, 1'b1, 1'b0);
        check("tl_pixel", 16'({pix_on, pix_color}), 16'h15);

        // Transparent code inside the sprite
        step(111, 50, 1'b1, 1'b0);
        check("transp_rom_add", 16'(rom_add), 16'h00B);
        step(112, 50, 1'b1, 1'b0);
        step(113, 50, 1'b1, 1'b0);
        check("transp_pixel", 16'({pix_on, pix_color}), 16'h0);
        scan_row(50, 114, 120);
        scan_row(57, 95, 120);
        idle(3);

        // Mirrored sprite
        spr_flip = 1'b1;
        step(0, 0, 1'b0, 1'b1);
        step(100, 50, 1'b1, 1'b0);
        check("flip_col_left", 16'(rom_add[3:0]), 16'd15);
        step(115, 50, 1'b1, 1'b0);
        check("flip_col_right", 16'(rom_add[3:0]), 16'd0);
        step(116, 50, 1'b1, 1'b0);
        step(117, 50, 1'b1, 1'b0);
        step(118, 50, 1'b1, 1'b0);
        check("flip_past_edge", 16'({pix_on, pix_color}), 16'h0);
        scan_row(63, 96, 118);
        scan_row(66, 96, 118);
        idle(3);

        // Animation stepping every DIV frames, then frozen
        spr_flip = 1'b0;
        anim_en  = 1'b1;
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < DIV; i++) step(0, 0, 1'b0, 1'b1);
            step(100, 50, 1'b1, 1'b0);
            check("anim_frame", 16'(rom_add[9:8]), 16'((g + 1) % NSPR));
        end
        for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b1);
        step(100, 50, 1'b1, 1'b0);
        check("anim_partial", 16'(rom_add[9:8]), 16'd0);
        anim_en = 1'b0;
        for (int i = 0; i < 2 * DIV; i++) step(0, 0, 1'b0, 1'b1);
        step(100, 50, 1'b1, 1'b0);
        check("anim_frozen", 16'(rom_add[9:8]), 16'd0);
        idle(3);

        // Right-edge placement must not wrap to column 0
        spr_x = 10'd1020;
        step(0, 0, 1'b0, 1'b1);
        scan_row(50, 1016, 1023);
        scan_row(50, 0, 11);
        check("edge_no_wrap", 16'(rom_add), 16'h003);
        idle(3);

        // New placement latched during an active hit applies next cycle
        spr_x = 10'd100;
        step(0, 0, 1'b0, 1'b1);
        scan_row(50, 100, 104);
        spr_x = 10'd300;
        step(105, 50, 1'b1, 1'b1);
        check("coinc_old_pos", 16'(rom_add), 16'h005);
        step(106, 50, 1'b1, 1'b0);
        check("coinc_new_pos", 16'(rom_add), 16'h005);
        scan_row(50, 107, 112);
        scan_row(51, 298, 318);
        idle(3);

        // Reset in the middle of a line blanks until the next frame_start
        spr_x = 10'd100;
        step(0, 0, 1'b0, 1'b1);
        scan_row(52, 100, 104);
        do_reset();
        scan_row(52, 105, 112);
        check("rst_mid_rom_add", 16'(rom_add), 16'h0);
        check("rst_mid_pixel", 16'({pix_on, pix_color}), 16'h0);
        step(0, 0, 1'b0, 1'b1);
        scan_row(53, 98, 117);
        idle(3);

        // Random placements
        for (int r = 0; r < 4; r++) begin
            spr_x    = 10'($urandom_range(0, 1000));
            spr_y    = 10'($urandom_range(0, 700));
            spr_flip = 1'($urandom_range(0, 1));
            anim_en  = 1'($urandom_range(0, 1));
            step(0, 0, 1'b0, 1'b1);
            for (int k = 0; k < 2; k++) begin
                scan_row(int'(spr_y) + int'($urandom_range(0, 17)),
                         (int'(spr_x) > 2) ? int'(spr_x) - 2 : 0,
                         int'(spr_x) + 18);
            end
            idle(3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
